// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: walks a register-file index range and streams each
// value out over a valid/ready port, one word per two cycles at best.
module reg_dump_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_last;
  logic [DATA_W-1:0] r_dout;
  logic [ADDR_W-1:0] r_dout_addr;
  logic              r_dout_valid;
  logic              w_accept;
  logic              w_at_last;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_accept  = r_dout_valid & dout_ready;
  assign w_at_last = (r_cur == r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_READ;
      S_READ: w_next = S_HOLD;
      S_HOLD: begin
        if (w_accept) w_next = w_at_last ? S_DONE : S_READ;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Range bounds are frozen at start so input changes mid-dump are harmless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur        <= '0;
      r_last       <= '0;
      r_dout       <= '0;
      r_dout_addr  <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur  <= first_addr;
            r_last <= last_addr;
          end
        end
        S_READ: begin
          r_dout       <= rd_data;
          r_dout_addr  <= r_cur;
          r_dout_valid <= 1'b1;
        end
        S_HOLD: begin
          if (w_accept) begin
            r_dout_valid <= 1'b0;
            if (!w_at_last) r_cur <= r_cur + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_addr = '0;
    if (r_state == S_READ || r_state == S_HOLD) w_rd_addr = r_cur;
  end

  assign rd_addr    = w_rd_addr;
  assign dout       = r_dout;
  assign dout_addr  = r_dout_addr;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb_reg_dump_ctrl: directed and randomized dumps checked against an
// index-range model of the expected word stream.
module tb_reg_dump_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] dout;
  logic [4:0]  dout_addr;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  int checks;
  int errors;

  assign rd_data = regs[rd_addr];

  reg_dump_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_valid"}, 64'(dout_valid), 64'(0));
    chk({tag, "_rdaddr"}, 64'(rd_addr), 64'(0));
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready low for 10 cycles
  task automatic run_dump(input int f, input int l, input int mode,
                          input bit poke);
    int cnt, k, dn, edges, stall;
    bit fin, ph, acc;
    logic [31:0] pd;
    logic [4:0]  pa, ea;
    cnt = ((l - f) & 31) + 1;
    k = 0; dn = 0; edges = 0; stall = 0;
    fin = 0; ph = 0; pd = '0; pa = '0;
    first_addr = 5'(f);
    last_addr  = 5'(l);
    start      = 1'b1;
    dout_ready = (mode == 0);
    @(posedge clk); edges++;
    @(negedge clk);
    start      = 1'b0;
    first_addr = 5'($urandom);
    last_addr  = 5'($urandom);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      ea = 5'(f + k);
      if (mode == 0)
        chk("cadence", 64'(dout_valid), 64'(cyc % 2 == 1));
      if (dout_valid) begin
        chk("addr", 64'(dout_addr), 64'(ea));
        chk("data", 64'(dout), 64'(regs[ea]));
        if (ph) begin
          chk("stable_data", 64'(dout), 64'(pd));
          chk("stable_addr", 64'(dout_addr), 64'(pa));
        end
      end
      if (busy && !done) chk("rd_addr", 64'(rd_addr), 64'(ea));
      if (done) begin
        dn++;
        chk("count", 64'(k), 64'(cnt));
        fin = 1;
      end
      unique case (mode)
        0: dout_ready = 1'b1;
        1: dout_ready = 1'($urandom_range(0, 1));
        default: begin
          dout_ready = (stall >= 10);
          if (dout_valid) stall++;
        end
      endcase
      if (fin) start = 1'b1;
      else if (poke && dout_valid && k == 1) begin
        start      = 1'b1;
        first_addr = 5'($urandom);
        last_addr  = 5'($urandom);
      end else start = 1'b0;
      acc = dout_valid && dout_ready;
      ph  = dout_valid && !dout_ready;
      pd  = dout;
      pa  = dout_addr;
      @(posedge clk); edges++;
      if (acc) k++;
      @(negedge clk);
    end
    if (!fin) chk("timeout", 64'(0), 64'(1));
    start = 1'b0;
    chk_idle("end");
    chk("done_pulses", 64'(dn), 64'(1));
    if (mode == 0) chk("span", 64'(edges), 64'(2 * cnt + 2));
    @(posedge clk);
    @(negedge clk);
    chk("no_restart", 64'(busy), 64'(0));
  endtask

  initial begin
    bit hit;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; dout_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h1111_1111;
    #3;
    chk_idle("rst");
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_daddr", 64'(dout_addr), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    first_addr = 5'd9; last_addr = 5'd12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("post_rst");
      chk("post_rst_dout", 64'(dout), 64'(0));
    end

    run_dump(0, 31, 0, 0);
    run_dump(30, 1, 0, 0);
    run_dump(7, 7, 2, 0);
    run_dump(0, 3, 0, 1);

    first_addr = 5'd0; last_addr = 5'd31;
    start = 1'b1; dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (dout_valid && dout_addr == 5'd5) begin
        dout_ready = 1'b0;
        hit = 1;
      end else @(negedge clk);
    end
    chk("reach_word5", 64'(hit), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_dout", 64'(dout), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'(0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_idle("abort_idle");
    end
    run_dump(2, 3, 0, 0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      run_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               (t % 2 == 0) ? 1 : 0, t == 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
